// File: rtl/fp32_addsub_arbiter_if.sv
// rtl/fp32_addsub_arbiter_if.sv - requester, shared-unit and response bundle for fp32_addsub_arbiter
interface fp32_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_op;
  logic                  fu_valid;
  logic [31:0]           fu_a;
  logic [31:0]           fu_b;
  logic                  fu_op;
  logic [31:0]           fu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, fu_result, rsp_ready,
    output req_ready, fu_valid, fu_a, fu_b, fu_op, rsp_valid, rsp_id, rsp_result
  );

  // Requesters, shared unit and consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, fu_result, rsp_ready,
    input  req_ready, fu_valid, fu_a, fu_b, fu_op, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/fp32_addsub_arbiter.sv
// rtl/fp32_addsub_arbiter.sv - round-robin sharing of one FP32 add/sub pipe with tagged in-order response FIFO; FPARB_STATS_EN adds grant/stall counters
module fp32_addsub_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 3,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fp32_addsub_arbiter_if.slave  bus
`ifdef FPARB_STATS_EN
  , output logic [16*NUM_REQ-1:0] stat_grants
  , output logic [15:0]           stat_stall
`endif
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  sel_q, sel_d;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             issue;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic [LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];

  logic [ID_W+31:0] fifo_mem_q [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scan: first valid at or above the pointer, else first valid from 0
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end

  // Credits are judged on registered occupancy only, so a same-cycle pop frees nothing yet
  assign issue = !rst && grant_found && (occ_q < CNT_W'(RESP_DEPTH));
  assign push  = tag_vld_q[LATENCY-1];
  assign pop   = bus.rsp_ready && (fifo_cnt_q != '0);

  // Grant fan-out, operand steering and next pointer
  always_comb begin
    sel_d    = issue ? grant_id : sel_q;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = issue && (grant_id == ID_W'(i));
    end
    bus.fu_valid = issue;
    bus.fu_a     = bus.req_a[32*sel_d +: 32];
    bus.fu_b     = bus.req_b[32*sel_d +: 32];
    bus.fu_op    = bus.req_op[sel_d];
  end

  // Occupancy covers ops in the unit plus queued responses
  always_comb begin
    occ_d = occ_q;
    case ({issue, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      occ_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      occ_q    <= occ_d;
    end
  end

  // Tag valids; clearing them on reset makes any late fu_result harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
      end
    end
  end

  // Tag ids travel alongside the valids and need no reset
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_id;
    for (int k = 1; k < LATENCY; k++) begin
      tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  // Response storage written as the tag leaves the last stage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {tag_id_q[LATENCY-1], bus.fu_result};
    end
  end

  // FIFO fill level
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // First-word-fall-through head
  always_comb begin
    bus.rsp_valid                 = (fifo_cnt_q != '0);
    {bus.rsp_id, bus.rsp_result}  = fifo_mem_q[rd_ptr_q];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt_q == CNT_W'(RESP_DEPTH))));

`ifdef FPARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] stall_cnt_q;

  // Saturating grant and credit-stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (grant_id == ID_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
        end
      end
      if ((|bus.req_valid) && !issue && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  // Flatten counters onto the stat ports
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[16*i +: 16] = grant_cnt_q[i];
    end
    stat_stall = stall_cnt_q;
  end
`endif
endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// tb/tb_fp32_addsub_arbiter.sv - directed self-checking bench for fp32_addsub_arbiter
module tb_fp32_addsub_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int LATENCY    = 3;
  localparam int RESP_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_addsub_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef FPARB_STATS_EN
  logic [16*NUM_REQ-1:0] stat_grants;
  logic [15:0]           stat_stall;
`endif

  fp32_addsub_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FPARB_STATS_EN
    , .stat_grants(stat_grants)
    , .stat_stall(stat_stall)
`endif
  );

  // Per-requester operands and hand-computed FP32 results
  logic [31:0] vec_a   [NUM_REQ];
  logic [31:0] vec_b   [NUM_REQ];
  logic        vec_op  [NUM_REQ];
  logic [31:0] exp_res [NUM_REQ];

  // Shared-unit model: a table of the sums this bench uses
  function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
    if (a == 32'h4000_0000 && b == 32'h4000_0000 && !op) return 32'h4080_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  op) return 32'h4000_0000;
    if (a == 32'h4080_0000 && b == 32'h3F80_0000 &&  op) return 32'h4040_0000;
    return 32'h7FC0_0001;
  endfunction

  logic [31:0] fu_pipe [LATENCY];
  always @(posedge clk) begin
    fu_pipe[0] <= fu_model(bus.fu_a, bus.fu_b, bus.fu_op);
    for (int k = 1; k < LATENCY; k++) fu_pipe[k] <= fu_pipe[k-1];
  end
  assign bus.fu_result = fu_pipe[LATENCY-1];

  // Record every accepted response
  logic [ID_W-1:0] id_q  [$];
  logic [31:0]     res_q [$];
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      id_q.push_back(bus.rsp_id);
      res_q.push_back(bus.rsp_result);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsps();
    id_q.delete();
    res_q.delete();
  endtask

  task automatic wait_rsps(input string tag, input int n, input int bound);
    int c;
    c = 0;
    while (id_q.size() < n && c < bound) begin
      tick();
      c++;
    end
    check(tag, 32'(id_q.size()), 32'(n));
  endtask

  task automatic check_rsp(input string tag, input int k, input int exp_id);
    if (k < id_q.size()) begin
      check({tag, "_id"},  32'(id_q[k]), 32'(exp_id));
      check({tag, "_res"}, res_q[k], exp_res[exp_id]);
    end else begin
      check({tag, "_present"}, 32'(id_q.size()), 32'(k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    int cyc;
    logic saw;

    vec_a[0] = 32'h3F80_0000; vec_b[0] = 32'h4000_0000; vec_op[0] = 1'b0; exp_res[0] = 32'h4040_0000;
    vec_a[1] = 32'h4000_0000; vec_b[1] = 32'h4000_0000; vec_op[1] = 1'b0; exp_res[1] = 32'h4080_0000;
    vec_a[2] = 32'h4040_0000; vec_b[2] = 32'h3F80_0000; vec_op[2] = 1'b1; exp_res[2] = 32'h4000_0000;
    vec_a[3] = 32'h4080_0000; vec_b[3] = 32'h3F80_0000; vec_op[3] = 1'b1; exp_res[3] = 32'h4040_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[32*i +: 32] = vec_a[i];
      bus.req_b[32*i +: 32] = vec_b[i];
      bus.req_op[i]         = vec_op[i];
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    check("reset_fu_valid",  32'(bus.fu_valid),  32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    rst = 1'b0;

    // Single add from requester 0 with exact latency
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("single_req_ready", 32'(bus.req_ready), 32'h1);
    check("single_fu_valid",  32'(bus.fu_valid),  32'h1);
    check("single_fu_a",      bus.fu_a,           32'h3F80_0000);
    check("single_fu_b",      bus.fu_b,           32'h4000_0000);
    check("single_fu_op",     32'(bus.fu_op),     32'h0);
    tick();
    bus.req_valid = '0;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      check($sformatf("single_early_rsp_t%0d", k), 32'(bus.rsp_valid), 32'h0);
      tick();
    end
    @(negedge clk);
    check("single_rsp_valid",  32'(bus.rsp_valid), 32'h1);
    check("single_rsp_id",     32'(bus.rsp_id),    32'h0);
    check("single_rsp_result", bus.rsp_result,     32'h4040_0000);
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("single_after_pop", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Subtract from requester 2 (pointer at 1 scans forward to 2)
    clear_rsps();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("sub_req_ready", 32'(bus.req_ready), 32'h4);
    check("sub_fu_op",     32'(bus.fu_op),     32'h1);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_rsps("sub_rsp_count", 1, 12);
    check_rsp("sub", 0, 2);
    bus.rsp_ready = 1'b0;

    // Wrap: pointer at 3, only requester 1 valid; pointer then sits at 2
    clear_rsps();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("wrap_ptr_next", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_rsps("wrap_rsp_count", 2, 12);
    check_rsp("wrap0", 0, 1);
    check_rsp("wrap1", 1, 2);

    // Requester 3 alone brings the pointer back to 0
    clear_rsps();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("r3_req_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    wait_rsps("r3_rsp_count", 1, 12);
    check_rsp("r3", 0, 3);

    // Fairness with all requesters valid and no consumer stall
    clear_rsps();
    bus.req_valid = 4'b1111;
    n_iss = 0;
    cyc   = 0;
    while (n_iss < 8 && cyc < 40) begin
      @(negedge clk);
      if (bus.fu_valid === 1'b1) begin
        check($sformatf("rr_grant_%0d", n_iss), 32'(bus.req_ready), 32'(1 << (n_iss % NUM_REQ)));
        n_iss++;
      end
      tick();
      cyc++;
    end
    bus.req_valid = '0;
    check("rr_issue_count", 32'(n_iss), 32'd8);
    wait_rsps("rr_rsp_count", 8, 24);
    for (int k = 0; k < 8; k++) check_rsp($sformatf("rr%0d", k), k, k % NUM_REQ);

    // Backpressure: credits cap issues at RESP_DEPTH
    clear_rsps();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    n_iss = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.fu_valid === 1'b1) n_iss++;
      tick();
    end
    check("bp_issue_count", 32'(n_iss), 32'd4);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_valid",       32'(bus.rsp_valid), 32'h1);
    check("bp_pop_same_cycle",  32'(bus.req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("bp_credit_fu_valid", 32'(bus.fu_valid),  32'h1);
    check("bp_credit_grant",    32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    wait_rsps("bp_rsp_count", 5, 24);
    check_rsp("bp0", 0, 0);
    check_rsp("bp1", 1, 1);
    check_rsp("bp2", 2, 2);
    check_rsp("bp3", 3, 3);
    check_rsp("bp4", 4, 0);

    // Reset with two ops in flight discards them
    clear_rsps();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("rstf_grant_a", 32'(bus.req_ready), 32'h2);
    tick();
    @(negedge clk);
    check("rstf_grant_b", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) saw = 1'b1;
      tick();
    end
    check("rstf_no_stale_rsp", 32'(saw), 32'h0);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("rstf_grant_restart", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    wait_rsps("rstf_rsp_count", 1, 12);
    check_rsp("rstf", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
